// File: rtl/boot_pkg.sv
// Shared types for the IMEM boot/run sequencer.
// State encoding and word geometry.
package boot_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    LOAD,
    WRITE,
    RUN,
    DONE
  } boot_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_byte_serializer.sv
// Splits a 32-bit word into four little-endian byte writes.
// last_byte flags the fourth byte; byte_out idles at zero.
module boot_byte_serializer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] word,
  output logic [7:0]  byte_out,
  output logic        last_byte
);

  localparam logic [1:0] IDX_PRELAST = 2'(BYTES_PER_WORD - 2);

  logic [23:0] rest;
  logic [1:0]  idx;
  logic        act;

  // Shift out one byte per cycle, LSB first, after a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rest      <= '0;
      idx       <= '0;
      act       <= 1'b0;
      byte_out  <= '0;
      last_byte <= 1'b0;
    end else if (clr) begin
      rest      <= '0;
      idx       <= '0;
      act       <= 1'b0;
      byte_out  <= '0;
      last_byte <= 1'b0;
    end else if (load) begin
      rest      <= word[31:8];
      idx       <= '0;
      act       <= 1'b1;
      byte_out  <= word[7:0];
      last_byte <= 1'b0;
    end else if (act) begin
      if (last_byte) begin
        act       <= 1'b0;
        last_byte <= 1'b0;
        byte_out  <= '0;
      end else begin
        byte_out  <= rest[7:0];
        rest      <= {8'h00, rest[23:8]};
        idx       <= idx + 1'b1;
        last_byte <= (idx == IDX_PRELAST);
      end
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/run sequencer: clears IMEM, loads a program, runs the core
// for a set number of cycles, then freezes it for inspection.
module imem_boot_ctrl
  import boot_pkg::*;
#(
  parameter int IMEM_BYTES = 256,
  parameter int ADDR_W     = 8,
  parameter int CYC_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [CYC_W-1:0]  run_cycles,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              core_reset,
  output logic              core_en,
  output logic              loading,
  output logic              done,
  output logic [ADDR_W-2:0] word_count,
  output logic              overflow_err
);

  localparam int WORDS = IMEM_BYTES / BYTES_PER_WORD;
  localparam logic [ADDR_W-2:0] WC_FULL = (ADDR_W-1)'(WORDS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMEM_BYTES - 1);

  boot_state_t       state_q, state_d;
  logic              s_ready_d, we_d, accept;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-2:0] wc_d;
  logic              err_d, ovf_q, ovf_d, last_q, last_d;
  logic [CYC_W-1:0]  lim_q, lim_d, cyc_q, cyc_d;
  logic              core_reset_d, core_en_d, loading_d, done_d;
  logic              ser_last;

  boot_byte_serializer u_ser (
    .clk       (clk),
    .rst       (reset),
    .clr       (reload),
    .load      (accept),
    .word      (s_data),
    .byte_out  (imem_wdata),
    .last_byte (ser_last)
  );

  // Next-state and next-output decode; reload overrides everything
  always_comb begin
    state_d   = state_q;
    s_ready_d = s_ready;
    we_d      = imem_we;
    addr_d    = imem_addr;
    wc_d      = word_count;
    err_d     = overflow_err;
    ovf_d     = ovf_q;
    last_d    = last_q;
    lim_d     = lim_q;
    cyc_d     = cyc_q;
    accept    = 1'b0;
    if (reload) begin
      state_d   = CLEAR;
      s_ready_d = 1'b0;
      we_d      = 1'b0;
      addr_d    = '0;
      wc_d      = '0;
      err_d     = 1'b0;
      ovf_d     = 1'b0;
      last_d    = 1'b0;
      cyc_d     = '0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          if (!imem_we) begin
            we_d   = 1'b1;
            addr_d = '0;
          end else if (imem_addr == ADDR_LAST) begin
            state_d   = LOAD;
            we_d      = 1'b0;
            s_ready_d = 1'b1;
          end else begin
            addr_d = imem_addr + 1'b1;
          end
        end
        LOAD: begin
          if (s_valid && s_ready) begin
            accept    = 1'b1;
            state_d   = WRITE;
            s_ready_d = 1'b0;
            last_d    = s_last;
            ovf_d     = (word_count == WC_FULL);
            we_d      = (word_count != WC_FULL);
            addr_d    = {word_count[ADDR_W-3:0], 2'b00};
            if (word_count == WC_FULL) err_d = 1'b1;
          end
        end
        WRITE: begin
          if (!ser_last) begin
            addr_d = imem_addr + 1'b1;
          end else begin
            we_d = 1'b0;
            if (!ovf_q) wc_d = word_count + 1'b1;
            if (last_q) begin
              state_d = RUN;
              lim_d   = run_cycles;
              cyc_d   = '0;
            end else begin
              state_d   = LOAD;
              s_ready_d = 1'b1;
            end
          end
        end
        RUN: begin
          cyc_d = cyc_q + 1'b1;
          if (lim_q != '0 && cyc_d == lim_q) state_d = DONE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = CLEAR;
        end
      endcase
    end
    core_reset_d = (state_d inside {CLEAR, LOAD, WRITE});
    loading_d    = core_reset_d;
    core_en_d    = (state_d == RUN);
    done_d       = (state_d == DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR;
      s_ready      <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      word_count   <= '0;
      overflow_err <= 1'b0;
      ovf_q        <= 1'b0;
      last_q       <= 1'b0;
      lim_q        <= '0;
      cyc_q        <= '0;
      core_reset   <= 1'b1;
      core_en      <= 1'b0;
      loading      <= 1'b1;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_ready      <= s_ready_d;
      imem_we      <= we_d;
      imem_addr    <= addr_d;
      word_count   <= wc_d;
      overflow_err <= err_d;
      ovf_q        <= ovf_d;
      last_q       <= last_d;
      lim_q        <= lim_d;
      cyc_q        <= cyc_d;
      core_reset   <= core_reset_d;
      core_en      <= core_en_d;
      loading      <= loading_d;
      done         <= done_d;
    end
  end

endmodule
